// File: rtl/fwuart_tx.sv
// Fixed-rate UART transmitter: one-entry holding register feeding a start/8-data/stop framer.
// Optional even-parity bit after data bit 7 when FWUART_TX_PARITY_EN is defined.
module fwuart_tx #(
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] t_dat,
  input  logic       t_valid,
  output logic       t_ready,
  input  logic       clock_x16,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef FWUART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] bit_idx;
  logic       stop_idx;
  logic       hold_full;
  logic [7:0] hold_reg;
  logic [7:0] shifter;
  logic       bit_end;

  assign bit_end = clock_x16 && (cnt == 4'd15);
  assign t_ready = !hold_full;
  assign busy    = (state != IDLE) || hold_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      hold_full <= 1'b0;
      hold_reg  <= '0;
      shifter   <= '0;
      tx        <= 1'b1;
    end else begin
      // Accept and transfer are mutually exclusive: accept needs hold_full=0, transfer needs 1.
      if (t_valid && !hold_full) begin
        hold_reg  <= t_dat;
        hold_full <= 1'b1;
      end
      if (clock_x16 && state != IDLE)
        cnt <= cnt + 4'd1;

      case (state)
        IDLE: begin
          if (hold_full) begin
            state     <= START;
            shifter   <= hold_reg;
            hold_full <= 1'b0;
            tx        <= 1'b0;
            cnt       <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shifter[0];
            cnt     <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef FWUART_TX_PARITY_EN
              state <= PARITY;
              tx    <= ^shifter;
`else
              state    <= STOP;
              tx       <= 1'b1;
              stop_idx <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shifter[bit_idx + 3'd1];
            end
          end
        end
`ifdef FWUART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            cnt      <= '0;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (STOP_BITS == 2 && !stop_idx) begin
              stop_idx <= 1'b1;
            end else if (hold_full) begin
              // Chain straight into the next frame with no idle cycle.
              state     <= START;
              shifter   <= hold_reg;
              hold_full <= 1'b0;
              tx        <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fwuart_tx.sv
// Self-checking bench for fwuart_tx: frames are predicted from the byte stream and the
// count of clock_x16 pulses since the start bit (16 pulses per bit).
module tb_fwuart_tx;

`ifdef FWUART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] t_dat;
  logic       t_valid, t_valid2;
  logic       t_ready, t_ready2;
  logic       clock_x16 = 1'b0;
  logic       tx, tx2, busy, busy2;

  int unsigned ncmp = 0, nfail = 0;
  int unsigned cyc = 0, pulse_cnt = 0, div = 0;
  bit          stall = 1'b0;

  fwuart_tx dut1 (
    .clock(clock), .reset(reset), .t_dat(t_dat), .t_valid(t_valid), .t_ready(t_ready),
    .clock_x16(clock_x16), .tx(tx), .busy(busy)
  );

  fwuart_tx #(.STOP_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .t_dat(t_dat), .t_valid(t_valid2), .t_ready(t_ready2),
    .clock_x16(clock_x16), .tx(tx2), .busy(busy2)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    div = (div + 1) % 4;
    clock_x16 = (div == 0) && !stall;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (clock_x16) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  // Offer a byte and return the edge number on which it is accepted.
  task automatic send(input bit sel, input logic [7:0] b, output int unsigned acc);
    int unsigned n = 0;
    t_dat = b;
    if (sel) t_valid2 = 1'b1; else t_valid = 1'b1;
    while (!(sel ? t_ready2 : t_ready) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("accept_timeout", 32'(n < 5000), 32'd1);
    acc = cyc + 1;
    @(negedge clock);
    if (sel) t_valid2 = 1'b0; else t_valid = 1'b0;
    t_dat = 8'($urandom);
  endtask

  // Wait for the start bit, then check every clock of the frame against the expected bit.
  task automatic check_frame(input bit sel, input logic [7:0] b, input int stops,
                             output int unsigned st, output int unsigned en);
    logic bits[$];
    int   n = 0;
    int   p0, k, nb;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (PAR == 1) bits.push_back(^b);
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    nb = bits.size();
    while (cur_tx(sel) !== 1'b0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("start_timeout", 32'(n < 5000), 32'd1);
    st = cyc;
    p0 = int'(pulse_cnt);
    n  = 0;
    while (int'(pulse_cnt) - p0 < 16 * nb && n < 20000) begin
      k = (int'(pulse_cnt) - p0) / 16;
      chk($sformatf("frame_bit%0d_byte%02h", k, b), 32'(cur_tx(sel)), 32'(bits[k]));
      @(negedge clock);
      n++;
    end
    chk("frame_timeout", 32'(n < 20000), 32'd1);
    en = cyc;
  endtask

  int unsigned a0, a1, a2, s0, s1, s2, e0, e1, e2;
  logic [7:0]  r0, r1, r2;
  logic        v;
  int          p0;
  int unsigned n;
  bit          saw_low;

  initial begin
    reset = 1'b1; t_valid = 1'b0; t_valid2 = 1'b0; t_dat = '0;
    repeat (3) @(negedge clock);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(t_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx2", 32'(tx2), 32'd1);
    chk("rst_ready2", 32'(t_ready2), 32'd0 + 32'd1);
    chk("rst_busy2", 32'(busy2), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single byte 0x55
    fork
      send(1'b0, 8'h55, a0);
      check_frame(1'b0, 8'h55, 1, s0, e0);
    join
    chk("single_latency", s0, a0 + 1);
    chk("single_len_ok", 32'((e0 - s0) <= (10 + PAR) * 64 && (e0 - s0) >= (10 + PAR) * 64 - 3), 32'd1);
    chk("single_idle_tx", 32'(tx), 32'd1);
    chk("single_idle_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clock);

    // Back-to-back 0xA5, 0x3C
    fork
      begin send(1'b0, 8'hA5, a0); send(1'b0, 8'h3C, a1); end
      begin
        check_frame(1'b0, 8'hA5, 1, s0, e0);
        chk("b2b_no_gap", 32'(tx), 32'd0);
        check_frame(1'b0, 8'h3C, 1, s1, e1);
      end
    join
    chk("b2b_accept_in_frame", 32'(a1 < e0), 32'd1);
    chk("b2b_accept_edge", a1, s0 + 1);
    chk("b2b_start", s1, e0);
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clock);

    // Backpressure with three random bytes
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    fork
      begin
        send(1'b0, r0, a0);
        send(1'b0, r1, a1);
        chk("bp_ready_low", 32'(t_ready), 32'd0);
        chk("bp_busy_high", 32'(busy), 32'd1);
        send(1'b0, r2, a2);
      end
      begin
        check_frame(1'b0, r0, 1, s0, e0);
        check_frame(1'b0, r1, 1, s1, e1);
        check_frame(1'b0, r2, 1, s2, e2);
      end
    join
    chk("bp_acc2", a1, s0 + 1);
    chk("bp_acc3", a2, s1 + 1);
    chk("bp_chain1", s1, e0);
    chk("bp_chain2", s2, e1);
    chk("bp_idle_tx", 32'(tx), 32'd1);
    repeat (3) @(negedge clock);

    // Random bytes with random idle gaps
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge clock);
      r0 = 8'($urandom);
      fork
        send(1'b0, r0, a0);
        check_frame(1'b0, r0, 1, s0, e0);
      join
      chk("rand_latency", s0, a0 + 1);
      chk("rand_idle_tx", 32'(tx), 32'd1);
    end

`ifdef FWUART_TX_PARITY_EN
    fork
      begin send(1'b0, 8'h07, a0); send(1'b0, 8'h03, a1); end
      begin check_frame(1'b0, 8'h07, 1, s0, e0); check_frame(1'b0, 8'h03, 1, s1, e1); end
    join
    chk("par_chain", s1, e0);
    repeat (3) @(negedge clock);
`endif

    // Reset during data bit 3 of 0xF0 with 0x99 held
    send(1'b0, 8'hF0, a0);
    @(negedge clock);
    p0 = int'(pulse_cnt);
    chk("rst_mid_start", 32'(tx), 32'd0);
    send(1'b0, 8'h99, a1);
    n = 0;
    while (int'(pulse_cnt) - p0 < 16 * 4 + 8 && n < 5000) begin @(negedge clock); n++; end
    chk("rst_mid_bit3", 32'(tx), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_ready", 32'(t_ready), 32'd1);
    chk("rst_mid_busy0", 32'(busy), 32'd0);
    reset = 1'b0;
    saw_low = 1'b0;
    repeat (200) begin @(negedge clock); if (tx !== 1'b1) saw_low = 1'b1; end
    chk("rst_drop_held", 32'(saw_low), 32'd0);
    fork
      send(1'b0, 8'h81, a0);
      check_frame(1'b0, 8'h81, 1, s0, e0);
    join
    chk("rst_after_latency", s0, a0 + 1);
    chk("rst_after_idle", 32'(busy), 32'd0);

    // Stall clock_x16 for 100 clocks during DATA
    fork
      begin
        send(1'b0, 8'h5A, a0);
        repeat (200) @(negedge clock);
        v = tx;
        stall = 1'b1;
        repeat (100) @(negedge clock);
        chk("stall_tx_frozen", 32'(tx), 32'(v));
        stall = 1'b0;
      end
      check_frame(1'b0, 8'h5A, 1, s0, e0);
    join
    chk("stall_len_ok", 32'((e0 - s0) >= (10 + PAR) * 64 + 97), 32'd1);
    chk("stall_idle", 32'(busy), 32'd0);

    // STOP_BITS=2 instance: single then back-to-back
    r0 = 8'($urandom); r1 = 8'($urandom);
    fork
      send(1'b1, r0, a0);
      check_frame(1'b1, r0, 2, s0, e0);
    join
    chk("sb2_latency", s0, a0 + 1);
    chk("sb2_idle_tx", 32'(tx2), 32'd1);
    chk("sb2_idle_busy", 32'(busy2), 32'd0);
    fork
      begin send(1'b1, r0, a0); send(1'b1, r1, a1); end
      begin check_frame(1'b1, r0, 2, s0, e0); check_frame(1'b1, r1, 2, s1, e1); end
    join
    chk("sb2_chain", s1, e0);
    chk("sb2_end_busy", 32'(busy2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
